// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the multicycle MEM stage.
// Helpers work at MAX_DW width; callers size-cast to their own DW.
package mem_pkg;

    localparam int MAX_DW = 128;
    localparam int MAX_NB = MAX_DW / 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic [MAX_NB-1:0] byte_en(input size_e sz, input logic [3:0] lane);
        logic [MAX_NB-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_NB; i++) begin
            case (sz)
                SZ_BYTE: m[i] = (i == int'(lane));
                SZ_HALF: m[i] = (i == int'(lane)) || (i == int'(lane) + 1);
                SZ_WORD: m[i] = 1'b1;
                default: m[i] = 1'b0;
            endcase
        end
        return m;
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-fill above it.
    function automatic logic [MAX_DW-1:0] load_extract(input logic [MAX_DW-1:0] word,
                                                       input size_e sz,
                                                       input logic [3:0] lane,
                                                       input logic sx);
        logic [MAX_DW-1:0] sh;
        logic [MAX_DW-1:0] r;
        sh = word >> {lane, 3'b000};
        case (sz)
            SZ_BYTE: r = {{(MAX_DW-8){sx & sh[7]}}, sh[7:0]};
            SZ_HALF: r = {{(MAX_DW-16){sx & sh[15]}}, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_mc_if.sv
// Request/response bundle between the EX/MEM register and the MEM stage.
interface mem_stage_mc_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          mem_r_en;
    logic          mem_w_en;
    logic [AW-1:0] alu_result;
    logic [DW-1:0] st_val;
    logic [1:0]    size;
    logic          sign_ext;
    logic [DW-1:0] mem_read_value;
    logic          stall;
    logic          addr_err;

    modport master (
        output mem_r_en, mem_w_en, alu_result, st_val, size, sign_ext,
        input  mem_read_value, stall, addr_err
    );

    modport slave (
        input  mem_r_en, mem_w_en, alu_result, st_val, size, sign_ext,
        output mem_read_value, stall, addr_err
    );
endinterface

// File: rtl/data_ram_be.sv
// Single-port synchronous RAM with per-byte write enables and registered read.
module data_ram_be #(
    parameter int DW    = 32,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DW/8-1:0]          be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata
);
    localparam int NB = DW / 8;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_stage_mc.sv
// Multicycle MEM stage: decodes the effective address into a local RAM window,
// holds the pipeline for LATENCY cycles per access and flags bad accesses. DW >= 16.
module mem_stage_mc
    import mem_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 1024,
    parameter int LATENCY   = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_stage_mc_if.slave  bus
);
    localparam int NB = DW / 8;
    localparam int OB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [AW-1:0] off;
    logic [IW-1:0] idx_in;
    logic [OB-1:0] lane_in;
    size_e         sz_in;
    logic          req;
    logic          bad;

    always_comb begin
        off     = bus.alu_result - AW'(BASE_ADDR);
        idx_in  = off[OB+IW-1:OB];
        lane_in = off[OB-1:0];
        sz_in   = size_e'(bus.size);
        req     = bus.mem_r_en | bus.mem_w_en;
        bad     = (bus.alu_result < AW'(BASE_ADDR))
               || (|off[AW-1:OB+IW])
               || (sz_in == SZ_HALF && off[0])
               || (sz_in == SZ_WORD && (|lane_in))
               || (sz_in == SZ_RSVD)
               || (bus.mem_r_en && bus.mem_w_en);
    end

    state_e        state;
    logic [CW-1:0] cnt_p1;
    logic          err_p1;
    logic [DW-1:0] rd_val;

    logic [IW-1:0] idx_p1;
    logic [OB-1:0] lane_p1;
    size_e         sz_p1;
    logic          sx_p1;
    logic          wr_p1;
    logic [DW-1:0] st_data_p1;

    logic [DW-1:0] ram_rdata;
    logic [IW-1:0] ram_addr;
    logic [NB-1:0] ram_be;
    logic          ram_we;
    logic          fire;

    // Request capture: IDLE -> BUSY boundary, data fields carry no reset
    always_ff @(posedge clk) begin
        if (state == IDLE && req && !bad) begin
            idx_p1     <= idx_in;
            lane_p1    <= lane_in;
            sz_p1      <= sz_in;
            sx_p1      <= bus.sign_ext;
            wr_p1      <= bus.mem_w_en;
            st_data_p1 <= bus.st_val << {lane_in, 3'b000};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt_p1 <= '0;
            err_p1 <= 1'b0;
            rd_val <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        err_p1 <= bad;
                        if (bad) begin
                            state <= DONE;
                        end else begin
                            cnt_p1 <= CW'(LATENCY - 1);
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_p1 == '0) begin
                        if (!wr_p1) begin
                            rd_val <= DW'(load_extract(MAX_DW'(ram_rdata), sz_p1,
                                                       4'(lane_p1), sx_p1));
                        end
                        state <= DONE;
                    end else begin
                        cnt_p1 <= cnt_p1 - 1'b1;
                    end
                end
                // The request still on the inputs here belongs to this access.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM read is issued in the accepting IDLE cycle so data is ready by the last BUSY cycle.
    always_comb begin
        fire     = (state == BUSY) && (cnt_p1 == '0);
        ram_we   = fire && wr_p1;
        ram_be   = NB'(byte_en(sz_p1, 4'(lane_p1)));
        ram_addr = (state == IDLE) ? idx_in : idx_p1;
    end

    data_ram_be #(
        .DW   (DW),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .be   (ram_be),
        .addr (ram_addr),
        .wdata(st_data_p1),
        .rdata(ram_rdata)
    );

    assign bus.stall          = rst & (((state == IDLE) & req) | (state == BUSY));
    assign bus.addr_err       = (state == DONE) & err_p1;
    assign bus.mem_read_value = rd_val;

endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed bench for mem_stage_mc with default parameters (BASE 1024, DEPTH 256, LATENCY 2).
module tb_mem_stage_mc;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_stage_mc_if #(.DW(32), .AW(32)) bus ();

  mem_stage_mc #(
    .DW(32), .AW(32), .DEPTH(256), .BASE_ADDR(1024), .LATENCY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] v, input logic [1:0] sz, input logic sx);
    bus.mem_r_en   = r;
    bus.mem_w_en   = w;
    bus.alu_result = a;
    bus.st_val     = v;
    bus.size       = sz;
    bus.sign_ext   = sx;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
  endtask

  // Counts stall cycles up to the first non-stalled (DONE) cycle, bounded.
  task automatic run(input string tag, input int exp_stall, input int exp_err,
                     input logic [31:0] exp_rv, input bit keep);
    int n;
    int e;
    bit done;
    n = 0;
    e = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.addr_err) e++;
      if (bus.stall && n < 20) n++;
      else done = 1'b1;
    end
    chk({tag, "/stall"}, 32'(n), 32'(exp_stall));
    chk({tag, "/err"}, 32'(e), 32'(exp_err));
    chk({tag, "/rv"}, bus.mem_read_value, exp_rv);
    if (!keep) idle();
  endtask

  task automatic access(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] v,
                        input logic [1:0] sz, input logic sx,
                        input int exp_stall, input int exp_err, input logic [31:0] exp_rv);
    @(posedge clk);
    #1;
    drive(r, w, a, v, sz, sx);
    run(tag, exp_stall, exp_err, exp_rv, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    chk("rst/stall", 32'(bus.stall), 32'd0);
    chk("rst/err", 32'(bus.addr_err), 32'd0);
    chk("rst/rv", bus.mem_read_value, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle/stall", 32'(bus.stall), 32'd0);

    // word store then load
    access("st_w1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 2'b10, 1'b0, 3, 0, 32'h0);
    access("ld_w1028", 1'b1, 1'b0, 32'd1028, 32'h0, 2'b10, 1'b0, 3, 0, 32'hDEADBEEF);

    // sub-word loads
    access("ld_b1029_sx", 1'b1, 1'b0, 32'd1029, 32'h0, 2'b00, 1'b1, 3, 0, 32'hFFFFFFBE);
    access("ld_b1029_zx", 1'b1, 1'b0, 32'd1029, 32'h0, 2'b00, 1'b0, 3, 0, 32'h000000BE);
    access("ld_h1030_sx", 1'b1, 1'b0, 32'd1030, 32'h0, 2'b01, 1'b1, 3, 0, 32'hFFFFDEAD);

    // partial store keeps other lanes; upper st_val bits must be ignored
    access("st_b1031", 1'b0, 1'b1, 32'd1031, 32'h77777711, 2'b00, 1'b0, 3, 0, 32'hFFFFDEAD);
    access("ld_w1028b", 1'b1, 1'b0, 32'd1028, 32'h0, 2'b10, 1'b0, 3, 0, 32'h11ADBEEF);

    // bad accesses: one stall cycle, one addr_err pulse, nothing changes
    access("e_ld_mis", 1'b1, 1'b0, 32'd1030, 32'h0, 2'b10, 1'b0, 1, 1, 32'h11ADBEEF);
    access("e_st_mis", 1'b0, 1'b1, 32'd1030, 32'hFFFFFFFF, 2'b10, 1'b0, 1, 1, 32'h11ADBEEF);
    access("e_below", 1'b1, 1'b0, 32'd1020, 32'h0, 2'b10, 1'b0, 1, 1, 32'h11ADBEEF);
    access("e_range", 1'b1, 1'b0, 32'd2048, 32'h0, 2'b10, 1'b0, 1, 1, 32'h11ADBEEF);
    access("e_rw", 1'b1, 1'b1, 32'd1028, 32'h0, 2'b10, 1'b0, 1, 1, 32'h11ADBEEF);
    access("e_rsvd", 1'b1, 1'b0, 32'd1028, 32'h0, 2'b11, 1'b0, 1, 1, 32'h11ADBEEF);
    access("e_h_odd", 1'b0, 1'b1, 32'd1029, 32'h0, 2'b01, 1'b0, 1, 1, 32'h11ADBEEF);
    access("ld_b1028", 1'b1, 1'b0, 32'd1028, 32'h0, 2'b00, 1'b0, 3, 0, 32'h000000EF);
    access("ld_w1028c", 1'b1, 1'b0, 32'd1028, 32'h0, 2'b10, 1'b0, 3, 0, 32'h11ADBEEF);

    // window edges: last and first RAM word
    access("st_w2044", 1'b0, 1'b1, 32'd2044, 32'h55AA33CC, 2'b10, 1'b0, 3, 0, 32'h11ADBEEF);
    access("ld_w2044", 1'b1, 1'b0, 32'd2044, 32'h0, 2'b10, 1'b0, 3, 0, 32'h55AA33CC);
    access("st_w1024", 1'b0, 1'b1, 32'd1024, 32'h01020304, 2'b10, 1'b0, 3, 0, 32'h55AA33CC);
    access("ld_h1026", 1'b1, 1'b0, 32'd1026, 32'h0, 2'b01, 1'b0, 3, 0, 32'h00000102);

    // reset during the first BUSY cycle aborts the store
    access("st_w1032", 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 2'b10, 1'b0, 3, 0, 32'h00000102);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 32'd1032, 32'h12345678, 2'b10, 1'b0);
    @(negedge clk);
    chk("abort/acc_stall", 32'(bus.stall), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort/stall", 32'(bus.stall), 32'd0);
    chk("abort/rv", bus.mem_read_value, 32'd0);
    chk("abort/err", 32'(bus.addr_err), 32'd0);
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst/stall", 32'(bus.stall), 32'd0);
    access("ld_w1032", 1'b1, 1'b0, 32'd1032, 32'h0, 2'b10, 1'b0, 3, 0, 32'hCAFEF00D);

    // back-to-back store then load with no idle gap
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 32'd1036, 32'h0BADC0DE, 2'b10, 1'b0);
    run("b2b_st", 3, 0, 32'hCAFEF00D, 1'b1);
    drive(1'b1, 1'b0, 32'd1036, 32'h0, 2'b10, 1'b0);
    run("b2b_ld", 3, 0, 32'h0BADC0DE, 1'b0);

    // halfword store into the upper lanes
    access("st_h1038", 1'b0, 1'b1, 32'd1038, 32'hFFFF8001, 2'b01, 1'b0, 3, 0, 32'h0BADC0DE);
    access("ld_w1036", 1'b1, 1'b0, 32'd1036, 32'h0, 2'b10, 1'b0, 3, 0, 32'h8001C0DE);
    access("ld_h1038", 1'b1, 1'b0, 32'd1038, 32'h0, 2'b01, 1'b1, 3, 0, 32'hFFFF8001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_mc.md
Name: mem_stage_mc

Overview:
Parametrised multicycle successor to the single-cycle MIPS MEM stage.
- Maps the ALU effective address onto a local data RAM window starting at BASE_ADDR.
- Supports byte, halfword and word loads/stores with optional sign extension.
- Models a configurable RAM access latency by holding the pipeline with a stall handshake.
- Sits between EX/MEM and MEM/WB; hazard unit consumes stall.

Parameters:
DW, 32, data word width in bits (multiple of 8)
AW, 32, address width of alu_result
DEPTH, 256, RAM depth in DW-bit words (power of 2)
BASE_ADDR, 1024, byte address of RAM word 0
LATENCY, 2, cycles spent in BUSY per access (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
mem_r_en  in  1  load request
mem_w_en  in  1  store request
alu_result  in  AW  byte effective address
st_val  in  DW  store data, right-aligned
size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
sign_ext  in  1  1: sign-extend sub-word loads; 0: zero-extend
mem_read_value  out  DW  load result, registered
stall  out  1  hold upstream pipeline registers
addr_err  out  1  one-cycle pulse: bad access dropped

Behaviour:
- Reset (rst=0, any time): state=IDLE, counter=0, mem_read_value=0, addr_err=0, stall=0. RAM contents are not cleared. An in-flight store is aborted and the RAM is left unchanged.
- Address decode:
  - off = alu_result - BASE_ADDR, computed at AW bits (modulo).
  - word index = off >> log2(DW/8); lane = low bits of off.
  - Byte order is little-endian: byte at lane k occupies bits [8k+7:8k].
- Error conditions, any of which marks the access bad:
  - alu_result < BASE_ADDR
  - word index >= DEPTH
  - halfword access with odd address
  - word access not DW/8-aligned
  - size=11
  - mem_r_en and mem_w_en both set
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request: stall=0; remain in IDLE.
- IDLE, request with no error:
  - Latch index, lane, size, sign_ext, st_val and the read/write flag.
  - Load counter with LATENCY-1; go to BUSY.
  - stall=1 combinationally in this cycle.
- IDLE, request with error: stall=1; go to DONE with the error flag set.
- BUSY: stall=1. Decrement counter each cycle. When counter==0:
  - Store: perform the RAM write with byte-lane enables for the latched size/lane; unselected bytes keep their old value.
  - Load: register the lane-extracted, extended data into mem_read_value.
  - Go to DONE.
- DONE:
  - stall=0, so the pipeline advances this cycle.
  - addr_err=1 only if the error flag is set.
  - Next state is IDLE unconditionally. The request still present on the inputs in DONE is never re-triggered.
- Latency: stall is high for LATENCY+1 cycles on a valid access and 1 cycle on an error.
- mem_read_value holds its value until the next successful load; stores and errors do not change it.
- An erroneous access writes nothing.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state typedef
  - function computing byte-enables from size and lane
  - function extracting and extending load data
- One sub-module, data_ram_be: synchronous single-port RAM, DEPTH x DW, per-byte write enables, registered read. No reset on the array.

Test Plan:
(All scenarios use defaults: BASE_ADDR=1024, DEPTH=256, LATENCY=2.)
1. Word store then load: store 0xDEADBEEF at 1028, then load word at 1028 -> stall high for exactly 3 cycles on each access; mem_read_value=0xDEADBEEF in the DONE cycle; addr_err stays 0.
2. Sub-word loads after scenario 1:
   - byte at 1029, sign_ext=1 -> 0xFFFFFFBE
   - byte at 1029, sign_ext=0 -> 0x000000BE
   - halfword at 1030, sign_ext=1 -> 0xFFFFDEAD
3. Partial store: store byte 0x11 at 1031, then load word at 1028 -> 0x11ADBEEF (other lanes preserved).
4. Errors, each -> stall high exactly 1 cycle, addr_err pulses once, RAM and mem_read_value unchanged:
   - word at 1030 (misaligned)
   - address 1020 (below BASE_ADDR)
   - address 2048 (index 256 >= DEPTH)
   - r_en and w_en both set
5. Reset mid-access: store 0x12345678 at 1032; drive rst=0 during the first BUSY cycle -> stall drops immediately and mem_read_value=0; after release, a load at 1032 returns the old contents.
6. Back-to-back: load immediately follows a store to the same address with no idle gap -> second access starts the cycle after DONE and returns the newly stored value.
